// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the dekatron step sequencer.
// Holds the sequencer state encoding, the digit/tube widths and the
// one-hot <-> binary digit helpers used by the encoder and the top.
package dekatron_pkg;

  localparam int DIGIT_W = 4;
  localparam int TUBE_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Digits above 9 map to cathode 0 so the tube always gets a legal load.
  function automatic logic [TUBE_W-1:0] onehot10(input logic [DIGIT_W-1:0] d);
    logic [TUBE_W-1:0] v;
    v = '0;
    for (int i = 0; i < TUBE_W; i++) begin
      v[i] = (d == i[DIGIT_W-1:0]);
    end
    if (v == '0) v[0] = 1'b1;
    return v;
  endfunction

  function automatic logic is_onehot(input logic [TUBE_W-1:0] v);
    return (v != '0) && ((v & (v - TUBE_W'(1))) == '0);
  endfunction

  // Returns 0 for anything that is not exactly one lit cathode.
  function automatic logic [DIGIT_W-1:0] encode10(input logic [TUBE_W-1:0] v);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < TUBE_W; i++) begin
      if (v[i]) d = i[DIGIT_W-1:0];
    end
    if (!is_onehot(v)) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/dekatron_onehot_enc.sv
// Purpose : 10-cathode one-hot to binary digit encoder with a one-hot valid flag.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_vec (tube cathodes) -> o_digit (0 if invalid), o_valid (exactly one bit set).
module dekatron_onehot_enc
  import dekatron_pkg::*;
(
  input  logic [TUBE_W-1:0]  i_vec,
  output logic [DIGIT_W-1:0] o_digit,
  output logic               o_valid
);

  assign o_digit = encode10(i_vec);
  assign o_valid = is_onehot(i_vec);

endmodule

// File: rtl/dekatron_step_sequencer.sv
// Purpose : drives one dekatron tube; turns step/load commands into guide
//           pulse / Set waveforms, tracks the digit and flags carry/borrow.
// Latency : step N -> N*(PULSE_CYCLES+SETTLE_CYCLES+1)+1 clocks to o_done;
//           load -> PULSE_CYCLES+SETTLE_CYCLES+2; count 0 -> 1.
// Backpressure: o_cmd_ready only in IDLE; commands presented while busy wait.
// Ports   : i_cmd_* command in, o_done/o_carry/o_borrow/o_fault status,
//           o_position decoded digit, o_pulse_right/o_pulse_left/o_set/o_dek_in
//           to the tube, i_dek_out/i_dek_ready from the tube.
// Option  : DEKATRON_TIMEOUT_EN adds a Ready timeout in CHECK that faults.
module dekatron_step_sequencer
  import dekatron_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_load,
  input  logic               i_cmd_dir,
  input  logic [DIGIT_W-1:0] i_cmd_count,
  input  logic [DIGIT_W-1:0] i_load_value,
  output logic               o_done,
  output logic               o_carry,
  output logic               o_borrow,
  output logic               o_fault,
  output logic [DIGIT_W-1:0] o_position,
  output logic               o_pulse_right,
  output logic               o_pulse_left,
  output logic               o_set,
  output logic [TUBE_W-1:0]  o_dek_in,
  input  logic [TUBE_W-1:0]  i_dek_out,
  input  logic               i_dek_ready
);

  if (PULSE_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dekatron_step_sequencer: cycle parameters must be >= 1");
  end

  localparam int MAX_PH = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_PH + 1);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT_W-1:0] r_steps;
  logic [DIGIT_W-1:0] r_prev;
  logic               r_dir;
  logic               r_is_load;

  logic [DIGIT_W-1:0] w_digit;
  logic               w_valid;
  logic               w_accept;
  logic               w_dir;
  logic               w_pulse_end;
  logic               w_settle_end;
  logic               w_tmo_end;
  logic [DIGIT_W-1:0] w_count;

  dekatron_onehot_enc u_enc (
    .i_vec   (i_dek_out),
    .o_digit (w_digit),
    .o_valid (w_valid)
  );

  assign w_accept     = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_dir        = w_accept ? i_cmd_dir : r_dir;
  assign w_pulse_end  = (r_cnt == CNT_W'(PULSE_CYCLES - 1));
  assign w_settle_end = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_count      = (i_cmd_count > 4'd9) ? 4'd9 : i_cmd_count;

`ifdef DEKATRON_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Counts consecutive CHECK cycles with Ready low; cleared outside CHECK.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tmo <= '0;
    end else if (r_state == ST_CHECK && !i_dek_ready) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_tmo_end = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_end = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_load)               w_next = ST_LOAD;
          else if (i_cmd_count == '0)   w_next = ST_DONE;
          else                          w_next = ST_PULSE;
        end
      end
      ST_LOAD, ST_PULSE: if (w_pulse_end) w_next = ST_SETTLE;
      ST_SETTLE:         if (w_settle_end) w_next = ST_CHECK;
      ST_CHECK: begin
        if (i_dek_ready) begin
          // Invalid readback aborts remaining steps.
          if (!w_valid || r_is_load || r_steps == 4'd1) w_next = ST_DONE;
          else                                          w_next = ST_PULSE;
        end else if (w_tmo_end) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_steps       <= '0;
      r_prev        <= '0;
      r_dir         <= 1'b0;
      r_is_load     <= 1'b0;
      o_cmd_ready   <= 1'b1;
      o_done        <= 1'b0;
      o_carry       <= 1'b0;
      o_borrow      <= 1'b0;
      o_fault       <= 1'b0;
      o_position    <= '0;
      o_pulse_right <= 1'b0;
      o_pulse_left  <= 1'b0;
      o_set         <= 1'b0;
      o_dek_in      <= TUBE_W'(1);
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state) ? r_cnt + CNT_W'(1) : '0;

      if (w_accept) begin
        o_carry   <= 1'b0;
        o_borrow  <= 1'b0;
        r_is_load <= i_cmd_load;
        if (i_cmd_load) begin
          o_fault  <= 1'b0;
          o_dek_in <= onehot10(i_load_value);
        end else begin
          r_dir   <= i_cmd_dir;
          r_steps <= w_count;
        end
      end

      // Digit before this pulse, for the wrap test in CHECK.
      if (w_next == ST_PULSE && r_state != ST_PULSE) r_prev <= w_digit;

      if (r_state == ST_CHECK && i_dek_ready) begin
        if (!w_valid) begin
          o_fault <= 1'b1;
        end else if (r_is_load) begin
          if (i_dek_out != o_dek_in) o_fault <= 1'b1;
        end else begin
          if (r_dir && r_prev == 4'd9 && w_digit == 4'd0)   o_carry  <= 1'b1;
          if (!r_dir && r_prev == 4'd0 && w_digit == 4'd9)  o_borrow <= 1'b1;
          r_steps <= r_steps - 4'd1;
        end
      end

      if (r_state == ST_CHECK && !i_dek_ready && w_tmo_end) o_fault <= 1'b1;

      o_cmd_ready   <= (w_next == ST_IDLE);
      o_done        <= (w_next == ST_DONE);
      o_pulse_right <= (w_next == ST_PULSE) && w_dir;
      o_pulse_left  <= (w_next == ST_PULSE) && !w_dir;
      o_set         <= (w_next == ST_LOAD);
      o_position    <= w_digit;
    end
  end

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// Bench for dekatron_step_sequencer with a behavioural tube model.
// Runs a table of commands back to back, then multi-cycle corner sequences.
module tb_dekatron_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_count = 4'd0;
  logic [3:0] load_value = 4'd0;
  logic       done, carry, borrow, fault;
  logic [3:0] position;
  logic       pulse_right, pulse_left, set_o;
  logic [9:0] dek_in, dek_out;
  logic       dek_ready = 1'b1;
  logic       force_bad = 1'b0;

  int checks = 0;
  int failures = 0;

  dekatron_step_sequencer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_load    (cmd_load),
    .i_cmd_dir     (cmd_dir),
    .i_cmd_count   (cmd_count),
    .i_load_value  (load_value),
    .o_done        (done),
    .o_carry       (carry),
    .o_borrow      (borrow),
    .o_fault       (fault),
    .o_position    (position),
    .o_pulse_right (pulse_right),
    .o_pulse_left  (pulse_left),
    .o_set         (set_o),
    .o_dek_in      (dek_in),
    .i_dek_out     (dek_out),
    .i_dek_ready   (dek_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [9:0] oh(input int d);
    logic [9:0] r;
    r = '0;
    r[d] = 1'b1;
    return r;
  endfunction

  function automatic int enc(input logic [9:0] v);
    int d;
    d = 0;
    for (int i = 0; i < 10; i++) if (v[i]) d = i;
    return d;
  endfunction

  // Tube model: advances on each rising guide pulse, loads while Set is high.
  int   tube_pos = 0;
  logic pr_q = 1'b0, pl_q = 1'b0;
  int   n_pr = 0, n_pl = 0, n_set = 0, n_overlap = 0;

  assign dek_out = force_bad ? 10'b0000000011 : oh(tube_pos);

  always @(negedge clk) begin
    pr_q <= pulse_right;
    pl_q <= pulse_left;
    if (pulse_right && !pr_q)     tube_pos <= (tube_pos + 1) % 10;
    else if (pulse_left && !pl_q) tube_pos <= (tube_pos + 9) % 10;
    else if (set_o)               tube_pos <= enc(dek_in);
    if (pulse_right && !pr_q) n_pr <= n_pr + 1;
    if (pulse_left && !pl_q)  n_pl <= n_pl + 1;
    if (set_o)                n_set <= n_set + 1;
    if ((pulse_right && pulse_left) || (set_o && (pulse_right || pulse_left)))
      n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues one command and waits for Done; lat=-1 if Done never came.
  task automatic do_cmd(input logic ld, input logic dir, input logic [3:0] cnt,
                        input logic [3:0] val, output int lat,
                        output int npr, output int npl, output int nset);
    int pr0, pl0, st0;
    @(negedge clk);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_dir = dir; cmd_count = cnt; load_value = val;
    pr0 = n_pr; pl0 = n_pl; st0 = n_set;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) chk("busy_ready_low", int'(cmd_ready), 0);
      if (done) begin
        lat = c;
        break;
      end
    end
    npr = n_pr - pr0; npl = n_pl - pl0; nset = n_set - st0;
  endtask

  typedef struct {
    logic       ld;
    logic       dir;
    logic [3:0] cnt;
    logic [3:0] val;
    int lat; int pos; int cy; int bo; int npr; int npl; int nset;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat, npr, npl, nset, ndone;

    vt[0] = '{1'b1, 1'b0, 4'd0,  4'd7,   8, 7, 0, 0, 0, 0, 4};
    vt[1] = '{1'b0, 1'b1, 4'd4,  4'd0,  29, 1, 1, 0, 4, 0, 0};
    vt[2] = '{1'b1, 1'b0, 4'd0,  4'd2,   8, 2, 0, 0, 0, 0, 4};
    vt[3] = '{1'b0, 1'b0, 4'd3,  4'd0,  22, 9, 0, 1, 0, 3, 0};
    vt[4] = '{1'b0, 1'b1, 4'd0,  4'd0,   1, 9, 0, 0, 0, 0, 0};
    vt[5] = '{1'b0, 1'b1, 4'd12, 4'd0,  64, 8, 1, 0, 9, 0, 0};
    vt[6] = '{1'b1, 1'b0, 4'd0,  4'd11,  8, 0, 0, 0, 0, 0, 4};
    vt[7] = '{1'b0, 1'b0, 4'd1,  4'd0,   8, 9, 0, 1, 0, 1, 0};
    vt[8] = '{1'b0, 1'b1, 4'd1,  4'd0,   8, 0, 1, 0, 1, 0, 0};
    vt[9] = '{1'b0, 1'b0, 4'd2,  4'd0,  15, 8, 0, 1, 0, 2, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_borrow", int'(borrow), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_pulses", int'({pulse_right, pulse_left, set_o}), 0);
    chk("rst_dek_in", int'(dek_in), 1);
    rst = 1'b0;

    // Table of back-to-back commands
    for (int i = 0; i < 10; i++) begin
      do_cmd(vt[i].ld, vt[i].dir, vt[i].cnt, vt[i].val, lat, npr, npl, nset);
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_position", i), int'(position), vt[i].pos);
      chk($sformatf("v%0d_carry", i), int'(carry), vt[i].cy);
      chk($sformatf("v%0d_borrow", i), int'(borrow), vt[i].bo);
      chk($sformatf("v%0d_fault", i), int'(fault), 0);
      chk($sformatf("v%0d_right_pulses", i), npr, vt[i].npr);
      chk($sformatf("v%0d_left_pulses", i), npl, vt[i].npl);
      chk($sformatf("v%0d_set_cycles", i), nset, vt[i].nset);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), int'(done), 0);
    end

    // Non-one-hot readback: fault after first step, rest skipped
    force_bad = 1'b1;
    do_cmd(1'b0, 1'b1, 4'd3, 4'd0, lat, npr, npl, nset);
    chk("bad_latency", lat, 8);
    chk("bad_fault", int'(fault), 1);
    chk("bad_right_pulses", npr, 1);
    chk("bad_position", int'(position), 0);
    force_bad = 1'b0;
    do_cmd(1'b1, 1'b0, 4'd0, 4'd0, lat, npr, npl, nset);
    chk("reload_latency", lat, 8);
    chk("reload_fault_clr", int'(fault), 0);
    chk("reload_position", int'(position), 0);

    // Reset in the middle of a guide pulse
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b1; cmd_count = 4'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_pulse_on", int'(pulse_right), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_pulse_drop", int'(pulse_right), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);

    // Ready held low in CHECK
    do_cmd(1'b1, 1'b0, 4'd0, 4'd5, lat, npr, npl, nset);
    chk("ld5_latency", lat, 8);
    dek_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_dir = 1'b1; cmd_count = 4'd1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
`ifdef DEKATRON_TIMEOUT_EN
    chk("tmo_done", ndone, 1);
    chk("tmo_fault", int'(fault), 1);
    dek_ready = 1'b1;
`else
    chk("wait_no_done", ndone, 0);
    chk("wait_no_fault", int'(fault), 0);
    dek_ready = 1'b1;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("wait_release_latency", lat, 1);
    chk("wait_position", int'(position), 6);
`endif

    repeat (3) @(negedge clk);
    chk("pulse_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dekatron_step_sequencer.md
Name: dekatron_step_sequencer

Overview:
- Synchronous controller that drives one dekatron counting tube: converts "step N positions left/right" and "load value" commands into the PulseRight/PulseLeft/Set waveforms the tube needs.
- Tracks decimal position and reports carry/borrow on wrap-around.
- Sits between the arithmetic/IP-DP control logic and each dekatron instance; one sequencer per tube.

Parameters:
- PULSE_CYCLES, 4, clocks a guide pulse (PulseRight/PulseLeft) stays high per step; minimum 1.
- SETTLE_CYCLES, 2, clocks with all pulses low after each guide pulse before Ready is sampled; minimum 1.
- TIMEOUT_CYCLES, 32, clocks to wait for Ready after settle before faulting (used only with DEKATRON_TIMEOUT_EN).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- CmdValid  in  1  command request; held until CmdReady.
- CmdReady  out  1  high only in IDLE; a command is accepted on the cycle where CmdValid & CmdReady.
- CmdLoad  in  1  1 = load LoadValue; 0 = step.
- CmdDir  in  1  1 = right (increment), 0 = left (decrement).
- CmdCount  in  4  number of steps, 0..9; values 10..15 are clamped to 9.
- LoadValue  in  4  decimal digit 0..9 to load; values >9 load 0.
- Done  out  1  one-clock pulse when a command completes (normal or fault).
- Carry  out  1  sticky per command: a right step wrapped 9->0; cleared on accept.
- Borrow  out  1  sticky per command: a left step wrapped 0->9; cleared on accept.
- Fault  out  1  sticky; Out not one-hot at check, or timeout; cleared only by Reset or an accepted load.
- Position  out  4  binary value of current tube digit (encoded from DekOut); 0 when not one-hot.
- PulseRight  out  1  to tube.
- PulseLeft  out  1  to tube.
- Set  out  1  to tube.
- DekIn  out  10  one-hot load vector to tube.
- DekOut  in  10  tube main-cathode outputs.
- DekReady  in  1  tube Ready.

Behaviour:
- All outputs registered. Reset state: IDLE. CmdReady=1; Done, Carry, Borrow, Fault, PulseRight, PulseLeft and Set all 0; DekIn=10'b0000000001.
- States: IDLE, LOAD, PULSE, SETTLE, CHECK, DONE.
- IDLE, accept with CmdLoad=1:
  - LOAD: Set=1 and DekIn=onehot(LoadValue) for PULSE_CYCLES, then SETTLE.
  - Load wins over step fields when CmdLoad=1.
- IDLE, accept with CmdLoad=0:
  - Count 0: go directly to DONE; no pulses issued. Latency from accept to Done is 1 clock.
  - Count >0: latch Dir and Count, then PULSE.
- PULSE: exactly one of PulseRight/PulseLeft is high for PULSE_CYCLES, then SETTLE.
  - The previous digit is captured on entry to PULSE, for the wrap check.
- SETTLE: all pulse and Set outputs low for SETTLE_CYCLES, then CHECK.
- CHECK: requires DekReady=1 and DekOut one-hot.
  - Right step with previous digit 9 and new digit 0: set Carry.
  - Left step with previous digit 0 and new digit 9: set Borrow.
  - Decrement the remaining count; if nonzero go to PULSE, else DONE.
  - After a load, CHECK compares DekOut with DekIn; a mismatch sets Fault.
  - Without DEKATRON_TIMEOUT_EN, CHECK waits indefinitely for DekReady.
- DONE: Done=1 for one clock, then IDLE.
- Step latency: N*(PULSE_CYCLES+SETTLE_CYCLES+1)+1 clocks from accept to Done, with DekReady already high at CHECK.
- Fault handling:
  - Not one-hot at CHECK: Fault=1, go to DONE, abort the remaining steps.
  - Fault does not block later commands.
- PulseRight and PulseLeft are never high in the same cycle. Set is never high with either of them.
- Reset mid-operation: pulses drop immediately (async); the command is lost; no Done pulse is issued.
- CmdValid while busy is ignored (CmdReady=0).

Optional Feature:
- Macro: DEKATRON_TIMEOUT_EN.
- Defined: a counter runs in CHECK. If DekReady stays low for TIMEOUT_CYCLES, set Fault and go to DONE.
- Undefined: no counter is present, and CHECK waits forever.

Decomposition:
- Package dekatron_pkg holds:
  - state enum
  - digit width constant 4
  - tube width constant 10
  - onehot10/encode10 functions, including the is_onehot check
- Sub-module dekatron_onehot_enc: 10-bit one-hot to 4-bit binary plus a valid flag. Used for Position and CHECK.

Test Plan:
- Reset; Load 7 -> Set high for 4 clocks, DekIn=10'b0010000000; Done after 4+2+1+1 clocks; Position=7; Carry=Borrow=Fault=0.
- Tube at 7; right step, Count=4 -> 4 PulseRight bursts; Position=1; Carry=1; Done at clock 29 after accept.
- Tube at 2; left step, Count=3 -> Position=9; Borrow=1; Carry=0.
- Count=0 -> Done on the next clock; no pulses; Position unchanged.
- Force DekOut=10'b0000000011 during CHECK -> Fault=1, Done pulse, remaining steps skipped. A following Load 0 clears Fault.
- Assert Reset in the middle of a PULSE -> PulseRight=0 in the same cycle; CmdReady=1; no Done. With DEKATRON_TIMEOUT_EN, holding DekReady=0 faults after 32 clocks.
